// File: rtl/rv32_regfile_alu_slice_if.sv
// Bus between the ID/EX/WB datapath and the register-file/ALU execute slice.
// The slave modport is the slice; the master modport is the surrounding datapath.
interface rv32_regfile_alu_slice_if #(
    parameter int unsigned DATA_W = 32
);
    logic [4:0]        rd_addr0;
    logic [4:0]        rd_addr1;
    logic [4:0]        wr_addr0;
    logic [DATA_W-1:0] wr_din0;
    logic              we0;
    logic [DATA_W-1:0] rd_dout0;
    logic [DATA_W-1:0] rd_dout1;
    logic [DATA_W-1:0] rs1_ex;
    logic [DATA_W-1:0] rs2_ex;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [3:0]        fs;
    logic [DATA_W-1:0] s;
    logic [3:0]        zcnv;
    logic [DATA_W-1:0] s_mem;

    modport master (
        output rd_addr0, rd_addr1, wr_addr0, wr_din0, we0, a_in, b_in, fs,
        input  rd_dout0, rd_dout1, rs1_ex, rs2_ex, s, zcnv, s_mem
    );

    modport slave (
        input  rd_addr0, rd_addr1, wr_addr0, wr_din0, we0, a_in, b_in, fs,
        output rd_dout0, rd_dout1, rs1_ex, rs2_ex, s, zcnv, s_mem
    );
endinterface

// File: rtl/rv32_regfile_alu_slice.sv
// RV32I execute slice: 32x32 register file with write-through reads, ID/EX operand
// registers, and a combinational ALU with ZCNV flags feeding the EX/MEM result register.
module rv32_regfile_alu_slice #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    rv32_regfile_alu_slice_if.slave  bus
);
    localparam int unsigned NumRegs = 32;
    localparam int unsigned Msb     = DATA_W - 1;

    typedef enum logic [2:0] {
        OpAddSub = 3'b000,
        OpSll    = 3'b001,
        OpSlt    = 3'b010,
        OpSltu   = 3'b011,
        OpXor    = 3'b100,
        OpShr    = 3'b101,
        OpOr     = 3'b110,
        OpAnd    = 3'b111
    } op_e;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] rd_dout0;
    logic [DATA_W-1:0] rd_dout1;
    logic [DATA_W-1:0] rs1_ex_d, rs1_ex_q;
    logic [DATA_W-1:0] rs2_ex_d, rs2_ex_q;
    logic [DATA_W-1:0] s_mem_d, s_mem_q;

    op_e               op;
    logic              is_sub;
    logic [DATA_W-1:0] a_op;
    logic [DATA_W-1:0] b_op;
    logic [DATA_W-1:0] b_add;
    logic [DATA_W:0]   sum;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_s;
    logic              flag_c;
    logic              flag_v;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.we0 && (bus.wr_addr0 != 5'd0)) begin
            regs_q[bus.wr_addr0] <= bus.wr_din0;
        end
    end

    // A write in flight is visible on the read ports in the same cycle.
    always_comb begin
        rd_dout0 = regs_q[bus.rd_addr0];
        if (bus.rd_addr0 == 5'd0) begin
            rd_dout0 = '0;
        end else if (bus.we0 && (bus.wr_addr0 == bus.rd_addr0)) begin
            rd_dout0 = bus.wr_din0;
        end
    end

    always_comb begin
        rd_dout1 = regs_q[bus.rd_addr1];
        if (bus.rd_addr1 == 5'd0) begin
            rd_dout1 = '0;
        end else if (bus.we0 && (bus.wr_addr0 == bus.rd_addr1)) begin
            rd_dout1 = bus.wr_din0;
        end
    end

    // ------------------------------------------------------------------
    // Function unit
    // ------------------------------------------------------------------
    assign a_op   = bus.a_in;
    assign b_op   = bus.b_in;
    assign op     = op_e'(bus.fs[3:1]);
    assign is_sub = (op == OpAddSub) && bus.fs[0];
    assign shamt  = b_op[4:0];

    // Subtraction shares the adder as A + ~B + 1, so C is the "no borrow" bit.
    assign b_add = is_sub ? ~b_op : b_op;
    assign sum   = {1'b0, a_op} + {1'b0, b_add} + {{DATA_W{1'b0}}, is_sub};

    always_comb begin
        alu_s  = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        unique case (op)
            OpAddSub: begin
                alu_s  = sum[Msb:0];
                flag_c = sum[DATA_W];
                flag_v = (a_op[Msb] == b_add[Msb]) && (sum[Msb] != a_op[Msb]);
            end
            OpSll:  alu_s = a_op << shamt;
            OpSlt:  alu_s = {{(DATA_W-1){1'b0}}, ($signed(a_op) < $signed(b_op))};
            OpSltu: alu_s = {{(DATA_W-1){1'b0}}, (a_op < b_op)};
            OpXor:  alu_s = a_op ^ b_op;
            OpShr: begin
                if (bus.fs[0]) begin
                    alu_s = $signed(a_op) >>> shamt;
                end else begin
                    alu_s = a_op >> shamt;
                end
            end
            OpOr:   alu_s = a_op | b_op;
            OpAnd:  alu_s = a_op & b_op;
            default: alu_s = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX and EX/MEM registers
    // ------------------------------------------------------------------
    assign rs1_ex_d = rd_dout0;
    assign rs2_ex_d = rd_dout1;
    assign s_mem_d  = alu_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_ex_q <= '0;
            rs2_ex_q <= '0;
            s_mem_q  <= '0;
        end else begin
            rs1_ex_q <= rs1_ex_d;
            rs2_ex_q <= rs2_ex_d;
            s_mem_q  <= s_mem_d;
        end
    end

    assign bus.rd_dout0 = rd_dout0;
    assign bus.rd_dout1 = rd_dout1;
    assign bus.rs1_ex   = rs1_ex_q;
    assign bus.rs2_ex   = rs2_ex_q;
    assign bus.s        = alu_s;
    assign bus.zcnv     = {(alu_s == '0), flag_c, alu_s[Msb], flag_v};
    assign bus.s_mem    = s_mem_q;

endmodule

// File: tb/tb_rv32_regfile_alu_slice.sv
// Self-checking bench for rv32_regfile_alu_slice: directed spec cases plus randomized
// register-file and ALU traffic checked against a behavioural model.
module tb_rv32_regfile_alu_slice;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] mdl [32];

    rv32_regfile_alu_slice_if #(.DATA_W(32)) bus ();

    rv32_regfile_alu_slice #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference ALU computed directly from the operation table with wide arithmetic.
    function automatic void alu_model(input logic [3:0] fs, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] s,
                                      output logic [3:0] zcnv);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] wide;
        int unsigned sh;
        logic        c;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = b % 32;
        c  = 1'b0;
        v  = 1'b0;
        case (fs)
            4'b0000: begin
                wide = {32'd0, a} + {32'd0, b};
                s    = wide[31:0];
                c    = wide[32];
                sr   = sa + sb;
                v    = (sr != longint'($signed(s)));
            end
            4'b0001: begin
                s  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr != longint'($signed(s)));
            end
            4'b0010, 4'b0011: s = a << sh;
            4'b0100, 4'b0101: s = (sa < sb) ? 32'd1 : 32'd0;
            4'b0110, 4'b0111: s = (a < b) ? 32'd1 : 32'd0;
            4'b1000, 4'b1001: s = a ^ b;
            4'b1010:          s = a >> sh;
            4'b1011:          s = 32'(sa >>> sh);
            4'b1100, 4'b1101: s = a | b;
            default:          s = a & b;
        endcase
        zcnv = {(s == 32'd0), c, s[31], v};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.we0 = 1'b0;
        tick();
        rst = 1'b0;
        bus.we0 = 1'b1; bus.wr_addr0 = 5'd5; bus.wr_din0 = 32'h0000_1234;
        bus.rd_addr0 = 5'd5; bus.rd_addr1 = 5'd5;
        bus.a_in = 32'd9; bus.b_in = 32'd4; bus.fs = 4'b0000;
        tick();
        checks++;
        if (bus.rs1_ex !== 32'h1234 || bus.s_mem !== 32'd13) begin
            failures++;
            $display("FAIL pre_reset rs1_ex=%h s_mem=%h required 00001234 0000000d",
                     bus.rs1_ex, bus.s_mem);
        end
        // Reset wins over a write requested on the same edge.
        bus.we0 = 1'b1; bus.wr_addr0 = 5'd6; bus.wr_din0 = 32'h5555_5555;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.we0 = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        #1;
        checks++;
        if (bus.rd_dout0 !== 32'd0) begin
            failures++;
            $display("FAIL reset_x5 rd_dout0=%h required 00000000", bus.rd_dout0);
        end
        checks++;
        if (bus.rs1_ex !== 32'd0 || bus.rs2_ex !== 32'd0 || bus.s_mem !== 32'd0) begin
            failures++;
            $display("FAIL reset_pipe rs1_ex=%h rs2_ex=%h s_mem=%h required all zero",
                     bus.rs1_ex, bus.rs2_ex, bus.s_mem);
        end
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr0 = 5'(i);
            bus.rd_addr1 = 5'(31 - i);
            #1;
            checks++;
            if (bus.rd_dout0 !== 32'd0 || bus.rd_dout1 !== 32'd0) begin
                failures++;
                $display("FAIL reset_read x%0d rd_dout0=%h rd_dout1=%h required 0",
                         i, bus.rd_dout0, bus.rd_dout1);
            end
        end
    endtask

    task automatic test_x0;
        bus.we0 = 1'b1; bus.wr_addr0 = 5'd0; bus.wr_din0 = 32'hDEAD_BEEF;
        bus.rd_addr0 = 5'd0; bus.rd_addr1 = 5'd0;
        #1;
        checks++;
        if (bus.rd_dout0 !== 32'd0 || bus.rd_dout1 !== 32'd0) begin
            failures++;
            $display("FAIL x0_bypass rd_dout0=%h rd_dout1=%h required 0",
                     bus.rd_dout0, bus.rd_dout1);
        end
        tick();
        bus.we0 = 1'b0;
        #1;
        checks++;
        if (bus.rd_dout0 !== 32'd0) begin
            failures++;
            $display("FAIL x0_write rd_dout0=%h required 00000000", bus.rd_dout0);
        end
    endtask

    task automatic test_write_bypass;
        bus.we0 = 1'b1; bus.wr_addr0 = 5'd7; bus.wr_din0 = 32'hCAFE_F00D;
        bus.rd_addr1 = 5'd7; bus.rd_addr0 = 5'd3;
        #1;
        checks++;
        if (bus.rd_dout1 !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL bypass rd_dout1=%h required cafef00d", bus.rd_dout1);
        end
        tick();
        mdl[7] = 32'hCAFE_F00D;
        bus.we0 = 1'b0;
        #1;
        checks++;
        if (bus.rs2_ex !== 32'hCAFE_F00D || bus.rd_dout1 !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL write_read rs2_ex=%h rd_dout1=%h required cafef00d",
                     bus.rs2_ex, bus.rd_dout1);
        end
    endtask

    task automatic test_alu_directed;
        logic [3:0]  t_fs [12];
        logic [31:0] t_a  [12];
        logic [31:0] t_b  [12];
        logic [31:0] t_s  [12];
        logic [3:0]  t_f  [12];
        t_fs = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0110,
                 4'b1011, 4'b1010, 4'b0010, 4'b0011, 4'b1111, 4'b1001};
        t_a  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd1, 32'hF0F0_1234, 32'hAAAA_AAAA};
        t_b  = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd1,
                 32'h24, 32'h24, 32'd31, 32'hFFFF_FFE4, 32'h0FF0_FF00, 32'hAAAA_AAAA};
        t_s  = '{32'd0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFE, 32'd1, 32'd0,
                 32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h10, 32'h00F0_1200, 32'd0};
        t_f  = '{4'b1100, 4'b0011, 4'b1100, 4'b0010, 4'b0000, 4'b1000,
                 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
        for (int i = 0; i < 12; i++) begin
            bus.fs = t_fs[i]; bus.a_in = t_a[i]; bus.b_in = t_b[i];
            #1;
            checks++;
            if (bus.s !== t_s[i] || bus.zcnv !== t_f[i]) begin
                failures++;
                $display("FAIL alu_directed[%0d] fs=%b s=%h zcnv=%b required s=%h zcnv=%b",
                         i, t_fs[i], bus.s, bus.zcnv, t_s[i], t_f[i]);
            end
        end
    endtask

    task automatic test_pipeline;
        bus.fs = 4'b0000; bus.a_in = 32'd2; bus.b_in = 32'd3;
        #1;
        checks++;
        if (bus.s !== 32'd5) begin
            failures++;
            $display("FAIL pipe_comb s=%h required 00000005", bus.s);
        end
        tick();
        checks++;
        if (bus.s_mem !== 32'd5) begin
            failures++;
            $display("FAIL pipe_latency s_mem=%h required 00000005", bus.s_mem);
        end
        bus.a_in = 32'd7;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        checks++;
        if (bus.s_mem !== 32'd0) begin
            failures++;
            $display("FAIL pipe_reset s_mem=%h required 00000000", bus.s_mem);
        end
        tick();
        checks++;
        if (bus.s_mem !== 32'd10) begin
            failures++;
            $display("FAIL pipe_resume s_mem=%h required 0000000a", bus.s_mem);
        end
    endtask

    task automatic test_random_regfile;
        logic        we;
        logic        do_rst;
        logic [4:0]  wa, ra0, ra1;
        logic [31:0] din, exp0, exp1;
        for (int n = 0; n < 300; n++) begin
            we     = 1'($urandom % 2);
            do_rst = ($urandom % 25) == 0;
            wa     = 5'($urandom);
            din    = $urandom;
            ra0    = (($urandom % 4) == 0) ? wa : 5'($urandom);
            ra1    = (($urandom % 4) == 0) ? wa : 5'($urandom);
            bus.we0 = we; bus.wr_addr0 = wa; bus.wr_din0 = din;
            bus.rd_addr0 = ra0; bus.rd_addr1 = ra1;
            rst = do_rst;
            exp0 = (ra0 == 0) ? 32'd0 : ((we && wa == ra0) ? din : mdl[ra0]);
            exp1 = (ra1 == 0) ? 32'd0 : ((we && wa == ra1) ? din : mdl[ra1]);
            #1;
            checks++;
            if (bus.rd_dout0 !== exp0 || bus.rd_dout1 !== exp1) begin
                failures++;
                $display("FAIL rand_read[%0d] x%0d=%h x%0d=%h required %h %h",
                         n, ra0, bus.rd_dout0, ra1, bus.rd_dout1, exp0, exp1);
            end
            tick();
            rst = 1'b0;
            if (do_rst) begin
                for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
                exp0 = 32'd0;
                exp1 = 32'd0;
            end else if (we && wa != 0) begin
                mdl[wa] = din;
            end
            checks++;
            if (bus.rs1_ex !== exp0 || bus.rs2_ex !== exp1) begin
                failures++;
                $display("FAIL rand_idex[%0d] rs1_ex=%h rs2_ex=%h required %h %h",
                         n, bus.rs1_ex, bus.rs2_ex, exp0, exp1);
            end
        end
        bus.we0 = 1'b0;
    endtask

    task automatic test_random_alu;
        logic [3:0]  f;
        logic [31:0] a, b, es;
        logic [3:0]  ez;
        for (int n = 0; n < 400; n++) begin
            f = 4'($urandom);
            a = pick_operand();
            b = pick_operand();
            bus.fs = f; bus.a_in = a; bus.b_in = b;
            alu_model(f, a, b, es, ez);
            #1;
            checks++;
            if (bus.s !== es || bus.zcnv !== ez) begin
                failures++;
                $display("FAIL rand_alu[%0d] fs=%b a=%h b=%h s=%h zcnv=%b required %h %b",
                         n, f, a, b, bus.s, bus.zcnv, es, ez);
            end
            tick();
            checks++;
            if (bus.s_mem !== es) begin
                failures++;
                $display("FAIL rand_smem[%0d] s_mem=%h required %h", n, bus.s_mem, es);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b0;
        bus.rd_addr0 = '0; bus.rd_addr1 = '0; bus.wr_addr0 = '0;
        bus.wr_din0 = '0; bus.we0 = 1'b0;
        bus.a_in = '0; bus.b_in = '0; bus.fs = '0;
        #1;
        test_reset();
        test_x0();
        test_write_bypass();
        test_alu_directed();
        test_pipeline();
        test_random_regfile();
        test_random_alu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
